// File: rtl/peripheral_system_timer_sequencer_if.sv
// Avalon-MM link between the timer sequencer (master) and the interval timer s1 port (slave).
// The timer IRQ travels with the bus because it comes from the same slave.
interface peripheral_system_timer_sequencer_if;
  logic [2:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [15:0] avm_writedata;
  logic [15:0] avm_readdata;
  logic        timer_irq;

  modport master (
    output avm_address,
    output avm_chipselect,
    output avm_write_n,
    output avm_writedata,
    input  avm_readdata,
    input  timer_irq
  );

  modport slave (
    input  avm_address,
    input  avm_chipselect,
    input  avm_write_n,
    input  avm_writedata,
    output avm_readdata,
    output timer_irq
  );
endinterface

// File: rtl/peripheral_system_timer_sequencer.sv
// Autonomous Avalon-MM initiator that programs the interval timer, services its timeouts,
// stops it on request and captures 32-bit counter snapshots. Every state is one bus cycle.
module peripheral_system_timer_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stop,
  input  logic        snap_req,
  input  logic [31:0] period,
  input  logic        continuous,
  peripheral_system_timer_sequencer_if.master avm,
  output logic        busy,
  output logic        running,
  output logic        tick,
  output logic [15:0] tick_count,
  output logic [31:0] snapshot,
  output logic        snapshot_valid
);

  localparam logic [2:0] REG_STATUS  = 3'd0;
  localparam logic [2:0] REG_CONTROL = 3'd1;
  localparam logic [2:0] REG_PERIODL = 3'd2;
  localparam logic [2:0] REG_PERIODH = 3'd3;
  localparam logic [2:0] REG_SNAPL   = 3'd4;
  localparam logic [2:0] REG_SNAPH   = 3'd5;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_PL,
    S_WR_PH,
    S_WR_CTL,
    S_RUN,
    S_CLR,
    S_SNAP_W,
    S_SNAP_RL,
    S_SNAP_RH,
    S_SNAP_DONE,
    S_STOP_CTL,
    S_STOP_CLR
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] period_reg, period_next;
  logic        continuous_reg, continuous_next;
  logic        stop_pending_reg, stop_pending_next;
  logic        snap_pending_reg, snap_pending_next;
  logic        guard_reg, guard_next;
  logic [15:0] tick_count_reg, tick_count_next;
  logic [15:0] snap_lo_reg, snap_lo_next;
  logic [31:0] snapshot_reg, snapshot_next;
  logic        in_run_phase;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= S_IDLE;
      period_reg       <= '0;
      continuous_reg   <= 1'b0;
      stop_pending_reg <= 1'b0;
      snap_pending_reg <= 1'b0;
      guard_reg        <= 1'b0;
      tick_count_reg   <= '0;
      snap_lo_reg      <= '0;
      snapshot_reg     <= '0;
    end else begin
      state_reg        <= state_next;
      period_reg       <= period_next;
      continuous_reg   <= continuous_next;
      stop_pending_reg <= stop_pending_next;
      snap_pending_reg <= snap_pending_next;
      guard_reg        <= guard_next;
      tick_count_reg   <= tick_count_next;
      snap_lo_reg      <= snap_lo_next;
      snapshot_reg     <= snapshot_next;
    end
  end

  assign in_run_phase = state_reg inside {S_RUN, S_CLR, S_SNAP_W, S_SNAP_RL, S_SNAP_RH,
                                          S_SNAP_DONE, S_STOP_CTL, S_STOP_CLR};

  always_comb begin
    state_next        = state_reg;
    period_next       = period_reg;
    continuous_next   = continuous_reg;
    tick_count_next   = tick_count_reg;
    snap_lo_next      = snap_lo_reg;
    snapshot_next     = snapshot_reg;
    // The slave holds its IRQ through the first RUN cycle after CLR; ignore it there.
    guard_next        = (state_reg == S_CLR);

    unique case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next      = S_WR_PL;
          period_next     = period;
          continuous_next = continuous;
          tick_count_next = '0;
        end
      end
      S_WR_PL:  state_next = S_WR_PH;
      S_WR_PH:  state_next = S_WR_CTL;
      S_WR_CTL: state_next = S_RUN;
      S_RUN: begin
        // Requests arriving this cycle count as pending so they are served without delay.
        if (stop_pending_reg || stop)
          state_next = S_STOP_CTL;
        else if (avm.timer_irq && !guard_reg)
          state_next = S_CLR;
        else if (snap_pending_reg || snap_req)
          state_next = S_SNAP_W;
      end
      S_CLR: begin
        tick_count_next = tick_count_reg + 16'd1;
        state_next      = continuous_reg ? S_RUN : S_IDLE;
      end
      S_SNAP_W:  state_next = S_SNAP_RL;
      S_SNAP_RL: state_next = S_SNAP_RH;
      S_SNAP_RH: begin
        snap_lo_next = avm.avm_readdata;
        state_next   = S_SNAP_DONE;
      end
      S_SNAP_DONE: begin
        snapshot_next = {avm.avm_readdata, snap_lo_reg};
        state_next    = S_RUN;
      end
      S_STOP_CTL: state_next = S_STOP_CLR;
      S_STOP_CLR: state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // Pending flags: a request consumed by the sequence it starts must not re-arm it.
  always_comb begin
    stop_pending_next = stop_pending_reg;
    snap_pending_next = snap_pending_reg;
    if (in_run_phase && stop)
      stop_pending_next = 1'b1;
    if (in_run_phase && snap_req)
      snap_pending_next = 1'b1;
    if (state_reg == S_RUN && state_next == S_STOP_CTL)
      stop_pending_next = 1'b0;
    if (state_reg == S_RUN && state_next == S_SNAP_W)
      snap_pending_next = 1'b0;
    if (state_next == S_IDLE) begin
      stop_pending_next = 1'b0;
      snap_pending_next = 1'b0;
    end
  end

  always_comb begin
    avm.avm_chipselect = 1'b0;
    avm.avm_write_n    = 1'b1;
    avm.avm_address    = REG_STATUS;
    avm.avm_writedata  = 16'h0000;
    unique case (state_reg)
      S_WR_PL: begin
        avm.avm_chipselect = 1'b1;
        avm.avm_write_n    = 1'b0;
        avm.avm_address    = REG_PERIODL;
        avm.avm_writedata  = period_reg[15:0];
      end
      S_WR_PH: begin
        avm.avm_chipselect = 1'b1;
        avm.avm_write_n    = 1'b0;
        avm.avm_address    = REG_PERIODH;
        avm.avm_writedata  = period_reg[31:16];
      end
      S_WR_CTL: begin
        avm.avm_chipselect = 1'b1;
        avm.avm_write_n    = 1'b0;
        avm.avm_address    = REG_CONTROL;
        avm.avm_writedata  = {13'd0, 1'b1, continuous_reg, 1'b1};
      end
      S_CLR, S_STOP_CLR: begin
        avm.avm_chipselect = 1'b1;
        avm.avm_write_n    = 1'b0;
        avm.avm_address    = REG_STATUS;
      end
      S_SNAP_W: begin
        avm.avm_chipselect = 1'b1;
        avm.avm_write_n    = 1'b0;
        avm.avm_address    = REG_SNAPL;
      end
      S_SNAP_RL: begin
        avm.avm_chipselect = 1'b1;
        avm.avm_address    = REG_SNAPL;
      end
      S_SNAP_RH: begin
        avm.avm_chipselect = 1'b1;
        avm.avm_address    = REG_SNAPH;
      end
      S_STOP_CTL: begin
        avm.avm_chipselect = 1'b1;
        avm.avm_write_n    = 1'b0;
        avm.avm_address    = REG_CONTROL;
        avm.avm_writedata  = 16'h0008;
      end
      default: ;
    endcase
  end

  assign busy           = (state_reg != S_IDLE);
  assign running        = in_run_phase;
  assign tick           = (state_reg == S_CLR);
  assign tick_count     = tick_count_reg;
  assign snapshot_valid = (state_reg == S_SNAP_DONE);
  // The high half arrives in the DONE cycle itself, so present it alongside the valid pulse.
  assign snapshot       = (state_reg == S_SNAP_DONE) ? {avm.avm_readdata, snap_lo_reg}
                                                     : snapshot_reg;

endmodule

// File: tb/tb_peripheral_system_timer_sequencer.sv
// Self-checking bench: behavioural timer slave, bus monitor and per-scenario checks
// against expected transaction lists, tick counts and snapshot values.
module tb_peripheral_system_timer_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        start, stop, snap_req, continuous;
  logic [31:0] period;
  logic        busy, running, tick, snapshot_valid;
  logic [15:0] tick_count;
  logic [31:0] snapshot;

  peripheral_system_timer_sequencer_if bus ();

  peripheral_system_timer_sequencer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .stop           (stop),
    .snap_req       (snap_req),
    .period         (period),
    .continuous     (continuous),
    .avm            (bus),
    .busy           (busy),
    .running        (running),
    .tick           (tick),
    .tick_count     (tick_count),
    .snapshot       (snapshot),
    .snapshot_valid (snapshot_valid)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] exp_ticks    = 16'd0;
  logic [31:0] exp_snapshot = 32'd0;

  // Behavioural timer slave
  logic [31:0] counter_value = 32'd0;
  logic [31:0] snap_latch    = 32'd0;
  logic        clr_pend      = 1'b0;
  logic        irq_fire      = 1'b0;
  logic        irq_r         = 1'b0;
  logic [15:0] rd_r          = 16'd0;

  assign bus.timer_irq    = irq_r;
  assign bus.avm_readdata = rd_r;

  always @(posedge clk) begin
    if (bus.avm_chipselect && !bus.avm_write_n &&
        (bus.avm_address == 3'd4 || bus.avm_address == 3'd5))
      snap_latch <= counter_value;
    clr_pend <= bus.avm_chipselect && !bus.avm_write_n && bus.avm_address == 3'd0;
    if (clr_pend)      irq_r <= 1'b0;
    else if (irq_fire) irq_r <= 1'b1;
    if (bus.avm_chipselect && bus.avm_write_n)
      rd_r <= (bus.avm_address == 3'd4) ? snap_latch[15:0] :
              (bus.avm_address == 3'd5) ? snap_latch[31:16] : 16'h0000;
  end

  // Bus monitor
  typedef struct packed {
    logic [2:0]  a;
    logic        w;
    logic [15:0] d;
  } txn_t;
  txn_t log_q[$];
  int tick_seen  = 0;
  int valid_seen = 0;

  always @(negedge clk) begin
    if (bus.avm_chipselect) begin
      log_q.push_back('{a: bus.avm_address, w: !bus.avm_write_n,
                        d: bus.avm_write_n ? 16'h0000 : bus.avm_writedata});
      $display("%0t bus %s addr=%0d data=0x%h", $time, bus.avm_write_n ? "read " : "write",
               bus.avm_address, bus.avm_writedata);
    end
    if (tick) tick_seen++;
    if (snapshot_valid) valid_seen++;
  end

  function automatic string tx(int a, bit w, logic [15:0] d);
    return $sformatf("%0d%s%h ", a, w ? "W" : "R", d);
  endfunction

  function automatic string seg_str(int from);
    string s = "";
    for (int i = from; i < log_q.size(); i++)
      s = {s, tx(int'(log_q[i].a), log_q[i].w, log_q[i].d)};
    return s;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; start = 0; stop = 0; snap_req = 0; continuous = 0; period = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 0 || running !== 0 || tick !== 0 || tick_count !== 0 || snapshot !== 0 ||
        snapshot_valid !== 0 || bus.avm_chipselect !== 0 || bus.avm_write_n !== 1 ||
        bus.avm_address !== 0 || bus.avm_writedata !== 0) begin
      errors++;
      $display("FAIL reset_state busy=%b run=%b tick=%b cnt=%h snap=%h sv=%b cs=%b wn=%b a=%0d d=%h required all idle/zero",
               busy, running, tick, tick_count, snapshot, snapshot_valid, bus.avm_chipselect,
               bus.avm_write_n, bus.avm_address, bus.avm_writedata);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_start(input logic [31:0] p, input bit c);
    @(negedge clk);
    period = p; continuous = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_ticks = 16'd0;
    checks++;
    if (!(bus.avm_chipselect && !bus.avm_write_n && bus.avm_address == 2 &&
          bus.avm_writedata == p[15:0] && busy && !running)) begin
      errors++;
      $display("FAIL start_wr_pl got a=%0d d=%h busy=%b run=%b required a=2 d=%h busy=1 run=0",
               bus.avm_address, bus.avm_writedata, busy, running, p[15:0]);
    end
    @(negedge clk);
    checks++;
    if (!(bus.avm_chipselect && !bus.avm_write_n && bus.avm_address == 3 &&
          bus.avm_writedata == p[31:16])) begin
      errors++;
      $display("FAIL start_wr_ph got a=%0d d=%h required a=3 d=%h",
               bus.avm_address, bus.avm_writedata, p[31:16]);
    end
    @(negedge clk);
    checks++;
    if (!(bus.avm_chipselect && !bus.avm_write_n && bus.avm_address == 1 &&
          bus.avm_writedata == (16'h0005 | (16'(c) << 1)) && !running)) begin
      errors++;
      $display("FAIL start_wr_ctl got a=%0d d=%h run=%b required a=1 d=%h run=0",
               bus.avm_address, bus.avm_writedata, running, 16'h0005 | (16'(c) << 1));
    end
    @(negedge clk);
    checks++;
    if (!(running && busy && !bus.avm_chipselect && tick_count == 16'd0)) begin
      errors++;
      $display("FAIL start_run got run=%b busy=%b cs=%b cnt=%h required run=1 busy=1 cs=0 cnt=0000",
               running, busy, bus.avm_chipselect, tick_count);
    end
  endtask

  task automatic test_ticks(input int n);
    int    t0  = tick_seen;
    int    idx = log_q.size();
    string exp = "";
    for (int i = 0; i < n; i++) begin
      int k = 0;
      irq_fire = 1'b1;
      @(negedge clk);
      irq_fire = 1'b0;
      while (irq_r && k < 20) begin
        @(negedge clk);
        k++;
      end
      checks++;
      if (irq_r !== 1'b0) begin
        errors++;
        $display("FAIL tick_irq_clear irq=%b after %0d cycles required 0", irq_r, k);
      end
      exp_ticks = exp_ticks + 16'd1;
      exp = {exp, tx(0, 1'b1, 16'h0000)};
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (tick_seen - t0 != n) begin
      errors++;
      $display("FAIL tick_pulses got %0d required %0d", tick_seen - t0, n);
    end
    checks++;
    if (tick_count !== exp_ticks) begin
      errors++;
      $display("FAIL tick_count got %h required %h", tick_count, exp_ticks);
    end
    checks++;
    if (seg_str(idx) != exp) begin
      errors++;
      $display("FAIL tick_bus got '%s' required '%s'", seg_str(idx), exp);
    end
  endtask

  task automatic test_snapshot(input logic [31:0] v);
    int idx = log_q.size();
    int v0  = valid_seen;
    string exp = {tx(4, 1'b1, 16'h0000), tx(4, 1'b0, 16'h0000), tx(5, 1'b0, 16'h0000)};
    counter_value = v;
    @(negedge clk);
    snap_req = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      snap_req = 1'b0;
      checks++;
      if (snapshot_valid !== (c == 4)) begin
        errors++;
        $display("FAIL snap_valid_timing cycle s+%0d got %b required %b", c, snapshot_valid, c == 4);
      end
    end
    exp_snapshot = v;
    checks++;
    if (snapshot !== exp_snapshot) begin
      errors++;
      $display("FAIL snap_value got %h required %h", snapshot, exp_snapshot);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (snapshot !== exp_snapshot || valid_seen - v0 != 1 || seg_str(idx) != exp) begin
      errors++;
      $display("FAIL snap_hold snap=%h pulses=%0d bus='%s' required %h, 1, '%s'",
               snapshot, valid_seen - v0, seg_str(idx), exp_snapshot, exp);
    end
  endtask

  task automatic test_stop_irq();
    int t0  = tick_seen;
    int idx = log_q.size();
    string exp = {tx(1, 1'b1, 16'h0008), tx(0, 1'b1, 16'h0000)};
    irq_fire = 1'b1;
    @(negedge clk);
    irq_fire = 1'b0;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 0 || running !== 0 || tick_seen != t0 || tick_count !== exp_ticks) begin
      errors++;
      $display("FAIL stop_irq_end busy=%b run=%b ticks=%0d cnt=%h required 0,0,0,%h",
               busy, running, tick_seen - t0, tick_count, exp_ticks);
    end
    checks++;
    if (seg_str(idx) != exp) begin
      errors++;
      $display("FAIL stop_irq_bus got '%s' required '%s'", seg_str(idx), exp);
    end
  endtask

  task automatic test_one_shot();
    int idx = log_q.size();
    int v0  = valid_seen;
    test_start($urandom, 1'b0);
    irq_fire = 1'b1;
    @(negedge clk);
    irq_fire = 1'b0;
    @(negedge clk);
    checks++;
    if (tick !== 1'b1) begin
      errors++;
      $display("FAIL oneshot_tick got %b required 1", tick);
    end
    snap_req = 1'b1;
    @(negedge clk);
    snap_req = 1'b0;
    exp_ticks = 16'd1;
    checks++;
    if (busy !== 0 || running !== 0 || tick_count !== exp_ticks) begin
      errors++;
      $display("FAIL oneshot_idle busy=%b run=%b cnt=%h required 0,0,%h", busy, running, tick_count, exp_ticks);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 0 || valid_seen != v0 || seg_str(idx + 3) != tx(0, 1'b1, 16'h0000)) begin
      errors++;
      $display("FAIL oneshot_drop busy=%b pulses=%0d bus='%s' required 0,0,'%s'",
               busy, valid_seen - v0, seg_str(idx + 3), tx(0, 1'b1, 16'h0000));
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    period = $urandom; continuous = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    exp_snapshot = 32'd0;
    exp_ticks    = 16'd0;
    checks++;
    if (busy !== 0 || running !== 0 || bus.avm_chipselect !== 0 || bus.avm_address !== 0 ||
        bus.avm_writedata !== 0 || bus.avm_write_n !== 1 || snapshot !== exp_snapshot ||
        tick_count !== exp_ticks) begin
      errors++;
      $display("FAIL reset_mid busy=%b run=%b cs=%b a=%0d d=%h snap=%h cnt=%h required idle and zero",
               busy, running, bus.avm_chipselect, bus.avm_address, bus.avm_writedata, snapshot, tick_count);
    end
    @(negedge clk);
    reset_n = 1'b1;
    test_start($urandom, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 1) == 0) test_ticks(int'($urandom_range(1, 2)));
      else test_snapshot($urandom);
    end
    begin
      int idx = log_q.size();
      string exp = {tx(4, 1'b1, 16'h0000), tx(4, 1'b0, 16'h0000), tx(5, 1'b0, 16'h0000),
                    tx(1, 1'b1, 16'h0008), tx(0, 1'b1, 16'h0000)};
      counter_value = $urandom;
      @(negedge clk);
      snap_req = 1'b1;
      @(negedge clk);
      snap_req = 1'b0;
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      repeat (8) @(negedge clk);
      checks++;
      if (busy !== 0 || seg_str(idx) != exp || snapshot !== counter_value) begin
        errors++;
        $display("FAIL b2b_stop_pending busy=%b snap=%h bus='%s' required 0,%h,'%s'",
                 busy, snapshot, seg_str(idx), counter_value, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start(32'h0007A11F, 1'b1);
    test_ticks(3);
    test_ticks(int'($urandom_range(2, 4)));
    test_snapshot(32'h00012345);
    test_snapshot($urandom);
    test_stop_irq();
    test_one_shot();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
